// File: rtl/mtr_drv.sv
// Converts signed PID speeds to complementary H-bridge PWM pairs with dead time; optional MTR_DUTY_CLAMP_EN.
// Latency: a captured speed applies from the next 2048-clk frame; outputs are registered; no backpressure.
module mtr_drv #(
    parameter int NONOVERLAP = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] lft_spd,
    input  logic [10:0] rght_spd,
    input  logic        drv_en,
    output logic        lft_PWM1,
    output logic        lft_PWM2,
    output logic        rght_PWM1,
    output logic        rght_PWM2,
    output logic        prd_strb
);

    localparam logic [5:0]  NOV      = 6'(NONOVERLAP);
    localparam logic [10:0] DUTY_MID = 11'h400;

    // Index 0 is the left side, index 1 the right side.
    logic [10:0]      r_cnt;
    logic [1:0][10:0] r_duty;
    logic [1:0]       r_raw;
    logic [1:0][5:0]  r_dt;
    logic [1:0]       r_pwm1;
    logic [1:0]       r_pwm2;
    logic             r_en_d;
    logic             r_prd_strb;

    logic [1:0][10:0] w_new_duty;
    logic [1:0]       w_raw_nxt;
    logic [1:0][5:0]  w_dt_nxt;
    logic [1:0]       w_act;
    logic             w_en_rise;

    function automatic logic [10:0] f_duty(input logic [10:0] spd);
        logic [10:0] d;
        d = {~spd[10], spd[9:0]};
`ifdef MTR_DUTY_CLAMP_EN
        if (d < 11'h040) begin
            d = 11'h040;
        end else if (d > 11'h7BF) begin
            d = 11'h7BF;
        end
`endif
        return d;
    endfunction

    // Disabling, re-enabling or a raw edge all restart the dead time, so the
    // outputs only ever come up after a full quiet interval.
    always_comb begin
        w_en_rise     = drv_en & ~r_en_d;
        w_new_duty[0] = f_duty(lft_spd);
        w_new_duty[1] = f_duty(rght_spd);
        for (int i = 0; i < 2; i++) begin
            w_raw_nxt[i] = (r_cnt < r_duty[i]);
            if (!drv_en || w_en_rise || (w_raw_nxt[i] != r_raw[i])) begin
                w_dt_nxt[i] = NOV;
            end else if (r_dt[i] != 6'd0) begin
                w_dt_nxt[i] = r_dt[i] - 6'd1;
            end else begin
                w_dt_nxt[i] = 6'd0;
            end
            w_act[i] = drv_en & (w_dt_nxt[i] == 6'd0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= 11'd0;
            r_duty     <= {DUTY_MID, DUTY_MID};
            r_raw      <= 2'b00;
            r_dt       <= '0;
            r_pwm1     <= 2'b00;
            r_pwm2     <= 2'b00;
            r_en_d     <= 1'b0;
            r_prd_strb <= 1'b0;
        end else begin
            r_cnt      <= r_cnt + 11'd1;
            r_prd_strb <= (r_cnt == 11'd2046);
            r_en_d     <= drv_en;
            r_raw      <= w_raw_nxt;
            r_dt       <= w_dt_nxt;
            r_pwm1     <= w_act & w_raw_nxt;
            r_pwm2     <= w_act & ~w_raw_nxt;
            if (r_cnt == 11'h7FF) begin
                r_duty <= w_new_duty;
            end
        end
    end

    assign lft_PWM1  = r_pwm1[0];
    assign lft_PWM2  = r_pwm2[0];
    assign rght_PWM1 = r_pwm1[1];
    assign rght_PWM2 = r_pwm2[1];
    assign prd_strb  = r_prd_strb;

endmodule

// File: tb/tb_mtr_drv.sv
// Bench for mtr_drv: timestamp-based reference model plus per-frame pulse-width checks.
module tb_mtr_drv;

    localparam int N = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] lft_spd = 11'd0;
    logic [10:0] rght_spd = 11'd0;
    logic        drv_en = 1'b0;
    logic        lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2, prd_strb;

    int checks = 0;
    int errors = 0;

    mtr_drv #(.NONOVERLAP(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lft_spd   (lft_spd),
        .rght_spd  (rght_spd),
        .drv_en    (drv_en),
        .lft_PWM1  (lft_PWM1),
        .lft_PWM2  (lft_PWM2),
        .rght_PWM1 (rght_PWM1),
        .rght_PWM2 (rght_PWM2),
        .prd_strb  (prd_strb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: frame position, duty per side, and the time of the most
    // recent disturbance (raw edge, drv_en low or drv_en rising) per side.
    int m_cnt = 0;
    int m_t = 0;
    int m_duty[2] = '{1024, 1024};
    int m_last[2] = '{-1000, -1000};
    bit m_raw[2] = '{0, 0};
    bit m_p1[2] = '{0, 0};
    bit m_p2[2] = '{0, 0};
    bit m_en = 0;
    bit m_prd = 0;

    function automatic int duty_of(input logic [10:0] spd);
        int d;
        d = $signed(spd) + 1024;
`ifdef MTR_DUTY_CLAMP_EN
        if (d < 64) d = 64;
        if (d > 1983) d = 1983;
`endif
        return d;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0; m_t = 0; m_en = 0; m_prd = 0;
            for (int s = 0; s < 2; s++) begin
                m_duty[s] = 1024; m_last[s] = -1000;
                m_raw[s] = 0; m_p1[s] = 0; m_p2[s] = 0;
            end
        end else begin
            m_t++;
            for (int s = 0; s < 2; s++) begin
                bit rn;
                bit act;
                rn = (m_cnt < m_duty[s]);
                if (rn != m_raw[s] || !drv_en || !m_en) m_last[s] = m_t;
                m_raw[s] = rn;
                act = drv_en && (m_t - m_last[s] >= N);
                m_p1[s] = act && rn;
                m_p2[s] = act && !rn;
                if (m_cnt == 2047) m_duty[s] = duty_of(s == 0 ? lft_spd : rght_spd);
            end
            m_en = drv_en;
            m_prd = (m_cnt == 2046);
            m_cnt = (m_cnt + 1) % 2048;
        end
    end

    int c_l1, c_l2, c_r1, c_r2;

    task automatic clr();
        c_l1 = 0; c_l2 = 0; c_r1 = 0; c_r2 = 0;
    endtask

    task automatic step();
        @(negedge clk);
        chk("lft_pwm1", lft_PWM1, m_p1[0]);
        chk("lft_pwm2", lft_PWM2, m_p2[0]);
        chk("rght_pwm1", rght_PWM1, m_p1[1]);
        chk("rght_pwm2", rght_PWM2, m_p2[1]);
        chk("prd_strb", prd_strb, m_prd);
        chk("overlap", (lft_PWM1 & lft_PWM2) | (rght_PWM1 & rght_PWM2), 0);
        c_l1 += int'(lft_PWM1); c_l2 += int'(lft_PWM2);
        c_r1 += int'(rght_PWM1); c_r2 += int'(rght_PWM2);
    endtask

    task automatic win(input string tag, input int e_l1, input int e_l2, input int e_r1, input int e_r2);
        clr();
        repeat (2048) step();
        chk({tag, "_l1"}, c_l1, e_l1);
        chk({tag, "_l2"}, c_l2, e_l2);
        chk({tag, "_r1"}, c_r1, e_r1);
        chk({tag, "_r2"}, c_r2, e_r2);
    endtask

    task automatic wait_strb();
        int k;
        k = 0;
        step();
        while (!prd_strb && k < 3000) begin
            step();
            k++;
        end
        chk("strb_wait", prd_strb, 1);
    endtask

    initial begin
        int lo;
        int pi;
        int r1_min, r2_min, r1_max, r2_max;
`ifdef MTR_DUTY_CLAMP_EN
        r1_min = 32;   r2_min = 1952; r1_max = 1951; r2_max = 33;
`else
        r1_min = 0;    r2_min = 2048; r1_max = 2015; r2_max = 0;
`endif
        lft_spd = 11'($urandom); rght_spd = 11'($urandom); drv_en = 1'($urandom);
        repeat (4) step();
        chk("rst_outs", {lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2, prd_strb}, 0);

        lft_spd = 11'd0; rght_spd = 11'd0; drv_en = 1'b1; rst_n = 1'b1;
        win("frame0", 992, 992, 992, 992);
        win("frame1", 992, 992, 992, 992);

        // Mid-frame speed change must not disturb the current frame.
        clr();
        repeat (700) step();
        lft_spd = 11'h200;
        repeat (1348) step();
        chk("upd_cur_l1", c_l1, 992);
        chk("upd_cur_l2", c_l2, 992);
        win("upd_nxt", 1504, 480, 992, 992);

        rght_spd = 11'h400;
        repeat (2048) step();
        win("r_min", 1504, 480, r1_min, r2_min);
        rght_spd = 11'h3FF;
        repeat (2048) step();
        win("r_max", 1504, 480, r1_max, r2_max);

        rght_spd = 11'd0;
        wait_strb();
        repeat (100) step();
        chk("en_pre_hi", lft_PWM1, 1);
        drv_en = 1'b0;
        step();
        chk("en_off", {lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2}, 0);
        repeat (100) step();
        drv_en = 1'b1;
        lo = 0;
        step();
        while (lft_PWM1 == 1'b0 && lft_PWM2 == 1'b0 && lo < 200) begin
            lo++;
            step();
        end
        chk("en_dead", lo, N);
        chk("en_resume", lft_PWM1, 1);
        wait_strb();
        pi = 0;
        do begin
            step();
            pi++;
        end while (!prd_strb && pi < 3000);
        chk("prd_period", pi, 2048);

        // Asynchronous reset between clock edges.
        repeat (300) step();
        chk("ar_pre_hi", lft_PWM1, 1);
        #2 rst_n = 1'b0;
        #1 chk("ar_outs", {lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2, prd_strb}, 0);
        step();
        rst_n = 1'b1;
        win("ar_50", 992, 992, 992, 992);

        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(199) == 0) lft_spd = 11'($urandom);
            if ($urandom_range(199) == 0) rght_spd = 11'($urandom);
            if ($urandom_range(499) == 0) drv_en = ~drv_en;
            if ($urandom_range(999) == 0) lft_spd = ($urandom_range(1) == 0) ? 11'h400 : 11'h3FF;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
